mips_data_mem: RTL and testbench

- Responder side of the core's data-memory port: services word read/write requests using the same 4-byte-lane interface the core drives.
- Adds a request/ready handshake and a programmable access latency, so the core can later be made to stall on slow memory.
- Storage is byte-addressed and big-endian. Lane 0 holds the byte at the request address.
- Sits between the MIPS core's mem_* signals and a byte-array store.

---
 rtl/mips_mem_pkg.sv | 17 +
 rtl/mem_byte_array.sv | 25 ++
 rtl/mips_data_mem.sv | 107 ++++++++++
 tb/tb_mips_data_mem.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS data-memory responder: byte lanes, word lanes and FSM states.
package mips_mem_pkg;

  typedef logic [7:0] byte_t;

  localparam int BYTE_LANES = 4;

  // Lane 0 is the leftmost (most significant) byte, matching big-endian storage order.
  typedef byte_t [0:BYTE_LANES-1] word_lanes_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_byte_array.sv
// Word-organised byte store: four byte lanes per entry, synchronous write, combinational read.
module mem_byte_array
  import mips_mem_pkg::*;
#(
  parameter int WORDS = 16384,
  parameter int IDX_W = 14
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  word_lanes_t      wdata_i,
  output word_lanes_t      rdata_o
);

  word_lanes_t mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mips_data_mem.sv
// Data-memory responder for the MIPS core: request/ready handshake with a programmable
// access latency, alignment/range checking and a big-endian 4-lane byte store.
module mips_data_mem
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES = 65536,
  parameter int LATENCY   = 4,
  localparam int ADDR_W   = $clog2(MEM_BYTES)
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  word_lanes_t mem_data_in,
  output word_lanes_t mem_data_out,
  output logic        mem_ready,
  output logic        mem_busy,
  output logic        mem_error
);

  localparam int WORDS = MEM_BYTES / BYTE_LANES;
  localparam int IDX_W = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_t       state_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      addr_q;
  logic             writeEn_q;
  word_lanes_t      wrData_q;
  word_lanes_t      rdData_q;
  logic             ready_q;
  logic             busy_q;
  logic             error_q;

  logic             addrError;
  logic             lastCycle;
  logic             commitWrite;
  word_lanes_t      arrayRdata;

  // Out-of-range addresses are flagged rather than aliased into the store.
  assign addrError   = (addr_q[1:0] != 2'b00) || ({1'b0, addr_q} >= 33'(MEM_BYTES));
  assign lastCycle   = (state_q == BUSY) && (count_q == '0);
  assign commitWrite = lastCycle && writeEn_q && !addrError && !rst_b;

  mem_byte_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (commitWrite),
    .idx_i   (IDX_W'(addr_q >> 2)),
    .wdata_i (wrData_q),
    .rdata_o (arrayRdata)
  );

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q  <= IDLE;
      count_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      rdData_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req) begin
            addr_q    <= mem_addr;
            writeEn_q <= mem_write_en;
            wrData_q  <= mem_data_in;
            count_q   <= CNT_W'(LATENCY - 1);
            busy_q    <= 1'b1;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          if (count_q == '0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            error_q <= addrError;
            if (!writeEn_q) begin
              rdData_q <= addrError ? '0 : arrayRdata;
            end
          end else begin
            count_q <= count_q - CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          error_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_data_out = rdData_q;
  assign mem_ready    = ready_q;
  assign mem_busy     = busy_q;
  assign mem_error    = error_q;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed self-checking bench for mips_data_mem: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for back-to-back throughput.
module tb_mips_data_mem;
  import mips_mem_pkg::*;

  logic        clk;
  logic        rst_b;

  logic        req;
  logic [31:0] addr;
  logic        we;
  word_lanes_t din;
  word_lanes_t dout;
  logic        ready;
  logic        busy;
  logic        error;

  logic        req1;
  logic [31:0] addr1;
  logic        we1;
  word_lanes_t din1;
  word_lanes_t dout1;
  logic        ready1;
  logic        busy1;
  logic        error1;

  int checkCount = 0;
  int errorCount = 0;
  int cyc = 0;

  mips_data_mem #(.MEM_BYTES(65536), .LATENCY(4)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_req      (req),
    .mem_addr     (addr),
    .mem_write_en (we),
    .mem_data_in  (din),
    .mem_data_out (dout),
    .mem_ready    (ready),
    .mem_busy     (busy),
    .mem_error    (error)
  );

  mips_data_mem #(.MEM_BYTES(65536), .LATENCY(1)) dut1 (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_req      (req1),
    .mem_addr     (addr1),
    .mem_write_en (we1),
    .mem_data_in  (din1),
    .mem_data_out (dout1),
    .mem_ready    (ready1),
    .mem_busy     (busy1),
    .mem_error    (error1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One request on the LATENCY=4 instance; measures latency, busy length and ready pulses.
  task automatic applyStimulus(input bit wrEn, input logic [31:0] a, input logic [31:0] d,
                               input bit holdReq, output int lat, output bit err,
                               output logic [31:0] rd, output int busyCycles, output int readyCount);
    @(negedge clk);
    req  = 1'b1;
    we   = wrEn;
    addr = a;
    din  = d;
    @(posedge clk); #1;
    if (!holdReq) req = 1'b0;
    lat = -1; err = 1'b0; rd = '0; busyCycles = 0; readyCount = 0;
    for (int n = 0; n < 20; n++) begin
      if (busy) busyCycles++;
      if (ready) begin
        readyCount++;
        if (lat < 0) begin
          lat = n; err = error; rd = dout;
        end
      end
      if (!busy && n > 0) break;
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  // Throughput stimulus for the LATENCY=1 instance.
  bit          tpWe   [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] tpAddr [3] = '{32'h40, 32'h40, 32'h0001_0000};
  logic [31:0] tpData [3] = '{32'hCAFE_BABE, 32'h0, 32'h0};

  initial begin
    int          lat;
    bit          err;
    logic [31:0] rd;
    int          busyCycles;
    int          readyCount;
    int          extraReady;
    int          rdyCyc  [3];
    bit          rdyErr  [3];
    logic [31:0] rdyData [3];

    rst_b = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; din = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_b = 1'b0;

    // Preload bytes 0..3, and read them back so mem_data_out is non-zero before reset.
    applyStimulus(1'b1, 32'h0, 32'h1122_3344, 1'b0, lat, err, rd, busyCycles, readyCount);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, lat, err, rd, busyCycles, readyCount);

    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_dout",  dout,       32'h0);
    @(negedge clk) rst_b = 1'b0;

    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("rd0_latency", 32'(lat),        32'd4);
    checkOutput("rd0_data",    rd,              32'h1122_3344);
    checkOutput("rd0_error",   32'(err),        32'd0);
    checkOutput("rd0_busy",    32'(busyCycles), 32'd5);
    checkOutput("rd0_pulses",  32'(readyCount), 32'd1);

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("wr10_error",   32'(err), 32'd0);
    checkOutput("wr10_latency", 32'(lat), 32'd4);
    checkOutput("wr10_dout",    rd,       32'h1122_3344);

    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("rd10_data",  rd,                         32'hDEAD_BEEF);
    checkOutput("byte10",     32'(dut.u_array.mem_q[4][0]), 32'hDE);
    checkOutput("byte13",     32'(dut.u_array.mem_q[4][3]), 32'hEF);

    applyStimulus(1'b1, 32'h12, 32'hAAAA_AAAA, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("wr12_error", 32'(err), 32'd1);
    checkOutput("wr12_dout",  rd,       32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h10, 32'h0, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("rd10_after_misaligned", rd, 32'hDEAD_BEEF);

    applyStimulus(1'b0, 32'h0001_0000, 32'h0, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("rd_oor_error", 32'(err), 32'd1);
    checkOutput("rd_oor_data",  rd,       32'h0);

    applyStimulus(1'b1, 32'h20, 32'h0102_0304, 1'b0, lat, err, rd, busyCycles, readyCount);
    checkOutput("wr20_error", 32'(err), 32'd0);

    // Write abandoned by a reset two cycles into BUSY.
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; din = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk) rst_b = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_b = 1'b0;
    extraReady = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ready) extraReady++;
    end
    checkOutput("midreset_no_ready", 32'(extraReady), 32'd0);

    // Request held high through BUSY and DONE still completes only once.
    applyStimulus(1'b0, 32'h20, 32'h0, 1'b1, lat, err, rd, busyCycles, readyCount);
    extraReady = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ready) extraReady++;
    end
    checkOutput("rd20_data",      rd,                            32'h0102_0304);
    checkOutput("held_req_pulses", 32'(readyCount + extraReady), 32'd1);

    // LATENCY=1 instance with mem_req held high across three requests.
    @(negedge clk);
    req1 = 1'b1; we1 = tpWe[0]; addr1 = tpAddr[0]; din1 = tpData[0];
    for (int k = 0; k < 3; k++) begin
      rdyCyc[k] = -100; rdyErr[k] = 1'b0; rdyData[k] = '0;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk); #1;
        if (ready1) begin
          rdyCyc[k] = cyc; rdyErr[k] = error1; rdyData[k] = dout1;
          break;
        end
      end
      if (k < 2) begin
        we1 = tpWe[k+1]; addr1 = tpAddr[k+1]; din1 = tpData[k+1];
      end else begin
        req1 = 1'b0;
      end
    end
    checkOutput("lat1_gap01",  32'(rdyCyc[1] - rdyCyc[0]), 32'd3);
    checkOutput("lat1_gap12",  32'(rdyCyc[2] - rdyCyc[1]), 32'd3);
    checkOutput("lat1_wr_err", 32'(rdyErr[0]),            32'd0);
    checkOutput("lat1_rd_data", rdyData[1],               32'hCAFE_BABE);
    checkOutput("lat1_rd_err", 32'(rdyErr[1]),            32'd0);
    checkOutput("lat1_oor_err", 32'(rdyErr[2]),           32'd1);
    checkOutput("lat1_oor_data", rdyData[2],              32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Global time bound so a wedged DUT cannot hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
